vga_timing_gen: RTL

Raster timing generator for the 640x480@60 Hz VGA output of the Nexys 4 DDR. It runs on the 100 MHz master clock and uses an internal pixel-rate clock enable instead of a derived clock. It produces pixel coordinates for the drawing logic and collects the returned colour one pixel period later. It then drives hsync, vsync and RGB to the connector pins, with all outputs aligned to that same pixel.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/pix_en_gen.sv | 39 +++
 rtl/vga_timing_gen.sv | 117 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and types for the Nexys 4 DDR video path.
// Sync windows are derived from the porch/sync widths so retiming only touches the basic counts.
package vga_pkg;

   localparam int CLK_PER_PIX = 4;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   localparam int COORD_W = 10;
   localparam int RGB_W   = 12;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [RGB_W-1:0]   rgb_t;

endpackage

// File: rtl/pix_en_gen.sv
// Pixel-rate clock enable: one-cycle pulse on the last master clock of every pixel period.
// Any pixel-rate logic can share this instead of running on a divided clock.
module pix_en_gen #(
   parameter int CLK_PER_PIX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic pix_tick
);

   localparam int TC_W = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
   localparam logic [TC_W-1:0] TC_LAST = TC_W'(CLK_PER_PIX - 1);

   logic [TC_W-1:0] tc;
   logic [TC_W-1:0] tc_next;
   logic            tick_q;

   always_comb begin
      tc_next = (tc == TC_LAST) ? '0 : tc + 1'b1;
   end

   // The tick is registered from the upcoming count so it lines up with tc == last.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tc     <= '0;
         tick_q <= 1'b0;
      end else if (!en) begin
         tc     <= '0;
         tick_q <= 1'b0;
      end else begin
         tc     <= tc_next;
         tick_q <= (tc_next == TC_LAST);
      end
   end

   assign pix_tick = tick_q & en;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel coordinates out to the drawing logic, then hsync/vsync/RGB
// registered one pixel later so every pin changes on the same clock edge.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_PER_PIX = vga_pkg::CLK_PER_PIX,
   parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
   parameter int H_FP        = vga_pkg::H_FP,
   parameter int H_SYNC      = vga_pkg::H_SYNC,
   parameter int H_BP        = vga_pkg::H_BP,
   parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
   parameter int V_FP        = vga_pkg::V_FP,
   parameter int V_SYNC      = vga_pkg::V_SYNC,
   parameter int V_BP        = vga_pkg::V_BP
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [RGB_W-1:0]   rgb_in,
   output logic               pix_tick,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic               video_on,
   output logic               frame_start,
   output logic               hsync,
   output logic               vsync,
   output logic [RGB_W-1:0]   rgb_out
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
   localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
   localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
   localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
   localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

   coord_t h_next;
   coord_t v_next;
   logic   wrap_h;
   logic   wrap_v;
   logic   hs_n;
   logic   vs_n;
   logic   fs_q;
   logic   running;

   pix_en_gen #(
      .CLK_PER_PIX (CLK_PER_PIX)
   ) u_pix_en (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .pix_tick (pix_tick)
   );

   always_comb begin
      wrap_h = (pix_x == H_LAST);
      wrap_v = (pix_y == V_LAST);
      h_next = wrap_h ? '0 : pix_x + 1'b1;
      v_next = pix_y;
      if (wrap_h) begin
         v_next = wrap_v ? '0 : pix_y + 1'b1;
      end
      hs_n = !((pix_x >= HS_FIRST) && (pix_x <= HS_LAST));
      vs_n = !((pix_y >= VS_FIRST) && (pix_y <= VS_LAST));
   end

   // Coordinate stage; running marks that the current (0,0) start has already been announced.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pix_x    <= '0;
         pix_y    <= '0;
         video_on <= 1'b1;
         fs_q     <= 1'b0;
         running  <= 1'b0;
      end else if (!en) begin
         pix_x    <= '0;
         pix_y    <= '0;
         video_on <= 1'b1;
         fs_q     <= 1'b0;
         running  <= 1'b0;
      end else begin
         running <= 1'b1;
         fs_q    <= 1'b0;
         if (pix_tick) begin
            pix_x    <= h_next;
            pix_y    <= v_next;
            video_on <= (h_next < H_ACT_C) && (v_next < V_ACT_C);
            fs_q     <= wrap_h && wrap_v;
         end
      end
   end

   assign frame_start = rst & en & (fs_q | ~running);

   // Display stage captures the pixel that is just ending, so pins trail coordinates by one pixel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hsync   <= 1'b1;
         vsync   <= 1'b1;
         rgb_out <= '0;
      end else if (!en) begin
         hsync   <= 1'b1;
         vsync   <= 1'b1;
         rgb_out <= '0;
      end else if (pix_tick) begin
         hsync   <= hs_n;
         vsync   <= vs_n;
         rgb_out <= video_on ? rgb_in : '0;
      end
   end

endmodule
